mag_cmp_seq: RTL and testbench

Parametrised sequential magnitude comparator: the clocked, multi-slice successor to the 4-bit cascadable 85-style comparator. It compares two WIDTH-bit unsigned words one SLICE-bit slice per clock, most-significant slice first. It honours the three cascade inputs and their 85-style truth table when the words are equal. It sits between operand registers and control logic that need wide compares without a wide combinational chain.

---
 rtl/mag_cmp_seq.sv | 160 ++++++++++++++++
 tb/tb_mag_cmp_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mag_cmp_seq.sv
// Sequential magnitude comparator: compares WIDTH-bit unsigned words one SLICE-bit slice per clock, MSB first,
// with 85-style cascade inputs. Define MAG_CMP_EARLY_EXIT_EN to stop at the first unequal slice (else fixed latency).
module mag_cmp_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             i_agb,
   input  logic             i_alb,
   input  logic             i_aeb,
   output logic             busy,
   output logic             done,
   output logic             q_agb,
   output logic             q_alb,
   output logic             q_aeb
);

   localparam int NSL = WIDTH / SLICE;
   localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             c_agb;
   logic             c_alb;
   logic             c_aeb;
   logic [IW-1:0]    idx;
`ifndef MAG_CMP_EARLY_EXIT_EN
   logic             dec;
   logic             dec_gt;
`endif

   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic             last;

   // NOTE: always_comb gives every output a default first, so no path can infer a latch.
   always_comb begin
      sa   = '0;
      sb   = '0;
      sa   = a_r[int'(idx)*SLICE +: SLICE];
      sb   = b_r[int'(idx)*SLICE +: SLICE];
      last = (idx == '0);
   end

   // NOTE: all state uses non-blocking assignments; operand registers are plain flops, so they are reset too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         a_r    <= '0;
         b_r    <= '0;
         c_agb  <= 1'b0;
         c_alb  <= 1'b0;
         c_aeb  <= 1'b0;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         q_agb  <= 1'b0;
         q_alb  <= 1'b0;
         q_aeb  <= 1'b0;
`ifndef MAG_CMP_EARLY_EXIT_EN
         dec    <= 1'b0;
         dec_gt <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  c_agb <= i_agb;
                  c_alb <= i_alb;
                  c_aeb <= i_aeb;
                  idx   <= IW'(NSL - 1);
                  q_agb <= 1'b0;
                  q_alb <= 1'b0;
                  q_aeb <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_RUN;
`ifndef MAG_CMP_EARLY_EXIT_EN
                  dec   <= 1'b0;
                  dec_gt <= 1'b0;
`endif
               end
            end

            S_RUN: begin
`ifdef MAG_CMP_EARLY_EXIT_EN
               if (sa != sb) begin
                  q_agb <= (sa > sb);
                  q_alb <= (sa < sb);
                  q_aeb <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (last) begin
                  q_aeb <= c_aeb;
                  q_agb <= ~c_aeb & ~c_alb;
                  q_alb <= ~c_aeb & ~c_agb;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
`else
               // Only the first unequal slice is remembered; later slices are walked but ignored.
               if (!dec && (sa != sb)) begin
                  dec    <= 1'b1;
                  dec_gt <= (sa > sb);
               end
               if (last) begin
                  if (dec) begin
                     q_agb <= dec_gt;
                     q_alb <= ~dec_gt;
                     q_aeb <= 1'b0;
                  end else if (sa != sb) begin
                     q_agb <= (sa > sb);
                     q_alb <= (sa < sb);
                     q_aeb <= 1'b0;
                  end else begin
                     q_aeb <= c_aeb;
                     q_agb <= ~c_aeb & ~c_alb;
                     q_alb <= ~c_aeb & ~c_agb;
                  end
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
`endif
            end

            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Self-checking bench for mag_cmp_seq: scoreboard of expected results/latencies, popped on each done pulse.
module tb_mag_cmp_seq;

   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int NSL   = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             i_agb;
   logic             i_alb;
   logic             i_aeb;
   logic             busy;
   logic             done;
   logic             q_agb;
   logic             q_alb;
   logic             q_aeb;

   mag_cmp_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .i_agb (i_agb),
      .i_alb (i_alb),
      .i_aeb (i_aeb),
      .busy  (busy),
      .done  (done),
      .q_agb (q_agb),
      .q_alb (q_alb),
      .q_aeb (q_aeb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic gt;
      logic lt;
      logic eq;
      int   lat;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic cg, input logic cl, input logic ce);
      exp_t e;
      logic [WIDTH-1:0] xa;
      logic [WIDTH-1:0] xb;
      e.gt  = (av > bv);
      e.lt  = (av < bv);
      e.eq  = 1'b0;
      if (av == bv) begin
         if (ce) e.eq = 1'b1;
         else begin
            e.gt = !cl;
            e.lt = !cg;
         end
      end
      e.lat = NSL;
`ifdef MAG_CMP_EARLY_EXIT_EN
      for (int k = 1; k <= NSL; k++) begin
         xa = (av >> ((NSL - k) * SLICE)) & WIDTH'((1 << SLICE) - 1);
         xb = (bv >> ((NSL - k) * SLICE)) & WIDTH'((1 << SLICE) - 1);
         if (xa != xb && e.lat == NSL) begin
            e.lat = k;
            break;
         end
      end
`else
      xa = '0;
      xb = '0;
`endif
      return e;
   endfunction

   // Called at a negedge with the DUT idle at the next edge; returns one negedge after the done cycle.
   task automatic run(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic [2:0] cas, input bit hold);
      exp_t e;
      int   n;
      bit   got;
      a     = av;
      b     = bv;
      {i_agb, i_alb, i_aeb} = cas;
      start = 1'b1;
      sbq.push_back(model(av, bv, cas[2], cas[1], cas[0]));
      @(negedge clk);
      n = 0;
      if (!hold) start = 1'b0;
      check("busy_after_start", busy, 1);
      got = 0;
      while (n < 20) begin
         if (done) begin
            got = 1;
            break;
         end
         @(negedge clk);
         n++;
         if (hold && n == 1) begin
            a = ~av;
            b = ~bv;
            {i_agb, i_alb, i_aeb} = ~cas;
         end
      end
      check("done_seen", got, 1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (got) begin
            check("q_agb", q_agb, e.gt);
            check("q_alb", q_alb, e.lt);
            check("q_aeb", q_aeb, e.eq);
            check("latency", n, e.lat);
            check("busy_at_done", busy, 0);
         end
      end
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("q_held", {q_agb, q_alb, q_aeb}, {e.gt, e.lt, e.eq});
   endtask

   initial begin
      bit saw;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      {i_agb, i_alb, i_aeb} = 3'b000;
      repeat (2) @(negedge clk);
      check("rst_outputs", {busy, done, q_agb, q_alb, q_aeb}, 5'b0);
      rst = 1'b0;

      run(16'h3105, 16'h1209, 3'b111, 0);
      run(16'h1209, 16'h3105, 3'b111, 0);
      for (int c = 0; c < 8; c++) run(16'h5932, 16'h5932, 3'(c), 0);
      run(16'h0005, 16'h0009, 3'b001, 0);
      run(16'hffff, 16'h0000, 3'b000, 0);
      run(16'h0000, 16'h0000, 3'b100, 0);

      // Start held high with operands scrambled mid-run; the following run is accepted back-to-back.
      run(16'h1234, 16'h1235, 3'b001, 1);
      run(16'h8765, 16'h8764, 3'b010, 0);

      for (int i = 0; i < 6; i++) run(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 0);

      // Reset in the second cycle of a full-length compare.
      a = 16'h5932;
      b = 16'h5932;
      {i_agb, i_alb, i_aeb} = 3'b001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_outputs", {busy, done, q_agb, q_alb, q_aeb}, 5'b0);
      @(negedge clk);
      rst = 1'b0;
      saw = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy) saw = 1;
      end
      check("no_done_after_rst", saw, 0);
      run(16'h4000, 16'h3fff, 3'b001, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
